// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle adder front-end: walks two captured operands one nibble per
// cycle through an external 4-bit carry-lookahead unit and assembles the
// full-width sum, carry-out and signed overflow.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | waiting for start; lookahead drive held at zero
// S_RUN  | one nibble per cycle through the lookahead unit; busy high
// S_DONE | single-cycle done pulse; a start here chains straight into S_RUN
module cla_nibble_sequencer #(
    parameter  int WIDTH   = 16,
    localparam int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [3:0]       p,
    output logic [3:0]       g,
    output logic             c_nib,
    input  logic [3:0]       s_nib,
    input  logic             cout_nib,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [3:0]         a_nib, b_nib;

    // State and datapath registers; reset wins over everything, including a
    // pending start, so an aborted addition leaves no partial result behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, nibble selection and lookahead drive.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        p       = 4'h0;
        g       = 4'h0;
        c_nib   = 1'b0;
        a_nib   = 4'h0;
        b_nib   = 4'h0;

        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                p       = a_nib ^ b_nib;
                g       = a_nib & b_nib;
                c_nib   = carry_q;
                carry_d = cout_nib;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = s_nib;
                    end
                end
                if (idx_q == IDX_W'(NIBBLES - 1)) begin
                    // Signed overflow is carry into the MSB xor carry out of it;
                    // the carry into the MSB is recovered from a^b^sum at that bit.
                    cout_d  = cout_nib;
                    ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_nib[3] ^ cout_nib;
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: doc/cla_nibble_sequencer.md
Name: cla_nibble_sequencer

Overview:
- Multi-cycle WIDTH-bit adder front-end. Sits directly upstream of the team's 4-bit carry-lookahead unit.
- Captures two operands and a carry-in on a start request, then walks them one nibble per cycle.
- Each cycle it drives per-bit propagate/generate and nibble carry-in into the lookahead unit, and registers the returned sum nibble and carry-out.
- Assembles the full-width sum, carry-out and signed overflow, and signals completion.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; number of RUN cycles per addition; not overridden directly.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled in IDLE or DONE.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry-in; sampled with start.
- p  output  4  propagate to lookahead unit, bit order [4:1]; bit k = a_nib[k-1]^b_nib[k-1].
- g  output  4  generate to lookahead unit, bit order [4:1]; bit k = a_nib[k-1]&b_nib[k-1].
- c_nib  output  1  nibble carry-in to lookahead unit.
- s_nib  input  4  sum nibble returned by lookahead unit (combinational from p, g, c_nib).
- cout_nib  input  1  nibble carry-out returned by lookahead unit.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  assembled sum; held until next accepted start.
- cout  output  1  final carry-out; held like sum.
- overflow  output  1  signed overflow; held like sum.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; idx, captured operands, carry register, sum, cout, overflow, done, busy all 0. Reset has priority over every other event.
- Reset mid-RUN aborts the addition. No done pulse; partial sum is cleared.
- States:
  - IDLE: start=1 -> capture a, b, cin; idx=0; carry_reg=cin; clear sum/cout/overflow -> RUN.
  - RUN: busy=1. p/g are driven combinationally from captured nibble idx; c_nib=carry_reg. At each edge: sum[4*idx+3:4*idx] <= s_nib; carry_reg <= cout_nib; idx++. At the edge with idx==NIBBLES-1: cout <= cout_nib; overflow <= a_cap[MSB]^b_cap[MSB]^s_nib[3]^cout_nib -> DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> capture and go to RUN (back-to-back, no IDLE bubble); otherwise -> IDLE.
- start in RUN is ignored; the captured operands are unaffected.
- Outside RUN, p=0, g=0, c_nib=0.
- Latency: start sampled at edge E0; nibbles processed at edges E1..E_NIBBLES; done high during the cycle after E_NIBBLES. For WIDTH=16, done is high in the 5th cycle after the start edge.
- Throughput: one addition per NIBBLES+1 cycles with back-to-back starts.
- sum/cout/overflow are valid from the done cycle and held until the next accepted start.
- Input a/b changes after capture have no effect.
- Arithmetic: sum = (a+b+cin) mod 2^WIDTH; cout = bit WIDTH of a+b+cin.
- The external lookahead path is purely combinational within one cycle. The block adds no pipeline register between p/g/c_nib and s_nib/cout_nib.

Test Plan:
- a=0x1234, b=0x4321, cin=0 -> p/g per nibble match a^b, a&b. Done in 5th cycle; sum=0x5555, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples across all nibbles (c_nib=1 in cycles 2-4); sum=0x0000, cout=1, overflow=0.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1. Then a=0x8000, b=0x8000 -> sum=0x0000, cout=1, overflow=1.
- a=0, b=0, cin=1 -> c_nib=1 in first RUN cycle only; sum=0x0001, cout=0.
- start re-pulsed with new operands during RUN -> ignored; result matches first operands. start held high in DONE with a=0x0001, b=0x0002 -> RUN next cycle; second done exactly 5 cycles later with sum=0x0003.
- rst asserted at 2nd RUN cycle -> next cycle state IDLE; sum=0, busy=0; no done pulse. A subsequent start computes correctly.
